// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Brief    : Instruction fetch controller. It issues word fetches to
//            instruction memory and holds one instruction for decode. It
//            applies jump, exception and eret redirects, and drains any
//            request that is abandoned while still outstanding.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
  parameter logic [31:0] IM_INIT = 32'h0000_3000,
  parameter logic [31:0] IM_END  = 32'h0000_4FFF,
  parameter logic [4:0]  NO_EXC  = 5'd0,
  parameter logic [4:0]  ADEL    = 5'd4
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        stall,
  input  logic        if_jump,
  input  logic [31:0] next_pc,
  input  logic        if_handler,
  input  logic [31:0] handler_pc,
  input  logic        if_eret,
  input  logic [31:0] epc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic [31:0] PC,
  output logic        instr_valid,
  output logic [4:0]  IFU_EXC
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] req_addr, req_addr_nxt;
  logic [31:0] instr_q, instr_nxt;
  logic [4:0]  exc_q, exc_nxt;

  logic        pc_legal;
  logic        redirect;
  logic [31:0] redirect_pc;

  // State and datapath registers; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state    <= S_FETCH;
      pc       <= IM_INIT;
      req_addr <= IM_INIT;
      instr_q  <= 32'd0;
      exc_q    <= NO_EXC;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      req_addr <= req_addr_nxt;
      instr_q  <= instr_nxt;
      exc_q    <= exc_nxt;
    end
  end

  // Next-state, redirect handling and memory request generation.
  always_comb begin
    pc_legal     = (pc >= IM_INIT) && (pc <= IM_END) && (pc[1:0] == 2'b00);
    // Handler and eret redirects win over everything, in any state and
    // regardless of stall; handler beats eret.
    redirect     = if_handler | if_eret;
    redirect_pc  = if_handler ? handler_pc : epc;

    state_nxt    = state;
    pc_nxt       = pc;
    req_addr_nxt = req_addr;
    instr_nxt    = instr_q;
    exc_nxt      = exc_q;
    mem_req      = 1'b0;
    mem_addr     = pc;

    case (state)
      S_FETCH: begin
        // Illegal addresses never reach memory; they turn into an ADEL
        // instruction on the following cycle.
        if (pc_legal) begin
          mem_req      = 1'b1;
          req_addr_nxt = pc;
        end
        if (redirect) begin
          pc_nxt    = redirect_pc;
          // A request still in flight must be drained before refetching so
          // mem_addr stays stable until the memory answers.
          state_nxt = (pc_legal && !mem_ready) ? S_FLUSH : S_FETCH;
        end else if (!pc_legal) begin
          instr_nxt = 32'd0;
          exc_nxt   = ADEL;
          state_nxt = S_HOLD;
        end else if (mem_ready) begin
          instr_nxt = mem_rdata;
          exc_nxt   = NO_EXC;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_nxt    = redirect_pc;
          state_nxt = S_FETCH;
        end else if (!stall) begin
          pc_nxt    = if_jump ? next_pc : pc + 32'd4;
          state_nxt = S_FETCH;
        end
      end
      S_FLUSH: begin
        // Keep presenting the abandoned request until it completes; its
        // data is dropped.
        mem_req  = 1'b1;
        mem_addr = req_addr;
        if (redirect) begin
          pc_nxt = redirect_pc;
        end
        if (mem_ready) begin
          state_nxt = S_FETCH;
        end
      end
      default: begin
        state_nxt = S_FETCH;
      end
    endcase

    if (Reset) begin
      mem_req = 1'b0;
    end
  end

  assign instr       = instr_q;
  assign PC          = pc;
  assign IFU_EXC     = exc_q;
  assign instr_valid = (state == S_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Brief    : Directed self-checking bench for fetch_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        Reset, stall, if_jump, if_handler, if_eret, mem_ready;
  logic [31:0] next_pc, handler_pc, epc, mem_rdata;
  logic        mem_req, instr_valid;
  logic [31:0] mem_addr, instr, PC;
  logic [4:0]  IFU_EXC;

  int checks = 0;
  int errors = 0;

  fetch_ctrl dut (
    .clk        (clk),
    .Reset      (Reset),
    .stall      (stall),
    .if_jump    (if_jump),
    .next_pc    (next_pc),
    .if_handler (if_handler),
    .handler_pc (handler_pc),
    .if_eret    (if_eret),
    .epc        (epc),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .instr      (instr),
    .PC         (PC),
    .instr_valid(instr_valid),
    .IFU_EXC    (IFU_EXC)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  // Serve one fetch of address a after lat wait cycles with rdata = a, then
  // check the held instruction. Leaves the DUT in HOLD.
  task automatic fetch_check(input logic [31:0] a, input int lat);
    for (int i = 0; i < lat; i++) begin
      #1;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== a || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL fetch_wait: req=%b addr=%h valid=%b expected 1/%h/0", mem_req, mem_addr, instr_valid, a);
      end
      tick();
    end
    mem_ready = 1'b1;
    mem_rdata = a;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== a) begin
      errors++;
      $display("FAIL fetch_ready: req=%b addr=%h expected 1/%h", mem_req, mem_addr, a);
    end
    tick();
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    #1;
    checks++;
    if (instr_valid !== 1'b1 || PC !== a || instr !== a || IFU_EXC !== 5'd0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL fetch_hold: valid=%b PC=%h instr=%h exc=%0d req=%b expected 1/%h/%h/0/0",
               instr_valid, PC, instr, IFU_EXC, mem_req, a, a);
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1; stall = 1'b0; if_jump = 1'b0; if_handler = 1'b0; if_eret = 1'b0;
    mem_ready = 1'b0; next_pc = 32'd0; handler_pc = 32'd0; epc = 32'd0; mem_rdata = 32'd0;
    tick();
    tick();
    #1;
    checks++;
    if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: req=%b valid=%b expected 0/0", mem_req, instr_valid);
    end
    checks++;
    if (PC !== 32'h3000 || instr !== 32'd0 || IFU_EXC !== 5'd0) begin
      errors++;
      $display("FAIL reset_regs: PC=%h instr=%h exc=%0d expected 3000/0/0", PC, instr, IFU_EXC);
    end
    Reset = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h3000) begin
      errors++;
      $display("FAIL reset_first_req: req=%b addr=%h expected 1/3000", mem_req, mem_addr);
    end
  endtask

  task automatic test_sequential;
    fetch_check(32'h3000, 2);
    tick();
    fetch_check(32'h3004, 2);
    tick();
    fetch_check(32'h3008, 2);
    tick();
  endtask

  task automatic test_stall;
    do_reset();
    fetch_check(32'h3000, 1);
    tick();
    fetch_check(32'h3004, 1);
    stall = 1'b1; if_jump = 1'b1; next_pc = 32'h3100;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (instr_valid !== 1'b1 || PC !== 32'h3004 || instr !== 32'h3004 || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_frozen: valid=%b PC=%h instr=%h req=%b expected 1/3004/3004/0",
                 instr_valid, PC, instr, mem_req);
      end
      tick();
    end
    stall = 1'b0;
    tick();
    if_jump = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h3100 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_jump: req=%b addr=%h valid=%b expected 1/3100/0", mem_req, mem_addr, instr_valid);
    end
  endtask

  task automatic test_handler_flush;
    do_reset();
    fetch_check(32'h3000, 0);
    tick();
    fetch_check(32'h3004, 0);
    tick();
    if_handler = 1'b1; handler_pc = 32'h4180;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h3008) begin
      errors++;
      $display("FAIL handler_issue: req=%b addr=%h expected 1/3008", mem_req, mem_addr);
    end
    tick();
    if_handler = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h3008 || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_hold_addr: req=%b addr=%h valid=%b expected 1/3008/0", mem_req, mem_addr, instr_valid);
      end
      tick();
    end
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ready = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h4180 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_refetch: req=%b addr=%h valid=%b expected 1/4180/0", mem_req, mem_addr, instr_valid);
    end
    fetch_check(32'h4180, 0);
  endtask

  task automatic test_eret_illegal;
    if_eret = 1'b1; epc = 32'h3002; stall = 1'b1;
    tick();
    if_eret = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL eret_no_req: req=%b valid=%b expected 0/0", mem_req, instr_valid);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      checks++;
      if (instr_valid !== 1'b1 || PC !== 32'h3002 || instr !== 32'd0 || IFU_EXC !== 5'd4 || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL eret_adel: valid=%b PC=%h instr=%h exc=%0d req=%b expected 1/3002/0/4/0",
                 instr_valid, PC, instr, IFU_EXC, mem_req);
      end
    end
    stall = 1'b0;
  endtask

  task automatic test_boundary;
    if_jump = 1'b1; next_pc = 32'h4FFC;
    tick();
    if_jump = 1'b0;
    fetch_check(32'h4FFC, 1);
    if_jump = 1'b1; next_pc = 32'h5000;
    tick();
    if_jump = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL bound_high_req: req=%b expected 0", mem_req);
    end
    tick();
    checks++;
    if (instr_valid !== 1'b1 || PC !== 32'h5000 || IFU_EXC !== 5'd4) begin
      errors++;
      $display("FAIL bound_high_exc: valid=%b PC=%h exc=%0d expected 1/5000/4", instr_valid, PC, IFU_EXC);
    end
    if_jump = 1'b1; next_pc = 32'h2FFC;
    tick();
    if_jump = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL bound_low_req: req=%b expected 0", mem_req);
    end
    tick();
    checks++;
    if (instr_valid !== 1'b1 || PC !== 32'h2FFC || IFU_EXC !== 5'd4) begin
      errors++;
      $display("FAIL bound_low_exc: valid=%b PC=%h exc=%0d expected 1/2ffc/4", instr_valid, PC, IFU_EXC);
    end
    if_jump = 1'b1; next_pc = 32'h3000;
    tick();
    if_jump = 1'b0;
    fetch_check(32'h3000, 0);
  endtask

  task automatic test_priority;
    stall = 1'b1;
    if_handler = 1'b1; handler_pc = 32'h3200;
    if_eret = 1'b1; epc = 32'h3300;
    if_jump = 1'b1; next_pc = 32'h3400;
    tick();
    if_handler = 1'b0; if_eret = 1'b0; if_jump = 1'b0; stall = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h3200) begin
      errors++;
      $display("FAIL priority: req=%b addr=%h expected 1/3200", mem_req, mem_addr);
    end
    if_eret = 1'b1; epc = 32'h3300; if_jump = 1'b1; next_pc = 32'h3400;
    tick();
    if_eret = 1'b0; if_jump = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'h1111_1111;
    tick();
    mem_ready = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h3300 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL eret_over_jump: req=%b addr=%h valid=%b expected 1/3300/0", mem_req, mem_addr, instr_valid);
    end
  endtask

  task automatic test_reset_mid_fetch;
    tick();
    Reset = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_gate_req: req=%b expected 0", mem_req);
    end
    tick();
    Reset = 1'b0; mem_ready = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h3000 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_refetch: req=%b addr=%h valid=%b expected 1/3000/0", mem_req, mem_addr, instr_valid);
    end
    tick();
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_spurious_valid: valid=%b expected 0", instr_valid);
    end
    fetch_check(32'h3000, 1);
  endtask

  task automatic test_spurious_ready;
    stall = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ready = 1'b0;
    #1;
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h3000 || PC !== 32'h3000) begin
      errors++;
      $display("FAIL spurious_ready: valid=%b instr=%h PC=%h expected 1/3000/3000", instr_valid, instr, PC);
    end
    stall = 1'b0;
    tick();
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h3004) begin
      errors++;
      $display("FAIL seq_after_hold: req=%b addr=%h expected 1/3004", mem_req, mem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_handler_flush();
    test_eret_illegal();
    test_boundary();
    test_priority();
    test_reset_mid_fetch();
    test_spurious_ready();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter IM_INIT, default 32'h0000_3000, lowest legal instruction address and reset PC.
REQ-002 Parameter IM_END, default 32'h0000_4FFF, highest legal instruction byte address.
REQ-003 Parameter NO_EXC, default 5'd0, exception code for a clean fetch.
REQ-004 Parameter ADEL, default 5'd4, exception code for a bad fetch address.
REQ-005 clk  in  1  clock, rising-edge.
REQ-006 Reset  in  1  reset, synchronous, active-high.
REQ-007 stall  in  1  decode cannot accept the held instruction.
REQ-008 if_jump  in  1  held instruction redirects to next_pc.
REQ-009 next_pc  in  32  jump/branch target.
REQ-010 if_handler  in  1  exception taken; redirect to handler_pc.
REQ-011 handler_pc  in  32  exception handler address.
REQ-012 if_eret  in  1  exception return; redirect to epc.
REQ-013 epc  in  32  exception return address.
REQ-014 mem_req  out  1  instruction memory request.
REQ-015 mem_addr  out  32  request address; stable while mem_req high.
REQ-016 mem_ready  in  1  memory returns mem_rdata this cycle.
REQ-017 mem_rdata  in  32  fetched word.
REQ-018 instr  out  32  held instruction to decode.
REQ-019 PC  out  32  address of instr.
REQ-020 instr_valid  out  1  instr/PC/IFU_EXC valid.
REQ-021 IFU_EXC  out  5  NO_EXC or ADEL for the held instruction.

Function
REQ-022 Registers: pc (current fetch/held address), req_addr (outstanding request address), instr, exc, state in {FETCH, HOLD, FLUSH}.
REQ-023 pc is legal iff IM_INIT <= pc <= IM_END and pc[1:0]==2'b00.
REQ-024 FETCH with illegal pc: mem_req=0; next cycle state HOLD, instr=0, IFU_EXC=ADEL, instr_valid=1.
REQ-025 FETCH with legal pc: mem_req=1, mem_addr=pc, req_addr<=pc; on mem_ready: instr<=mem_rdata, IFU_EXC<=NO_EXC, state HOLD (instr_valid=1 one cycle after mem_ready).
REQ-026 Once mem_req is raised it stays high with mem_addr unchanged until mem_ready, in FETCH and FLUSH.
REQ-027 HOLD: instr_valid=1, mem_req=0; when stall=0: pc<=next_pc if if_jump else pc+4 (32-bit wrap), state FETCH, instr_valid=0 next cycle.
REQ-028 HOLD with stall=1: pc, instr, IFU_EXC frozen; if_jump ignored.
REQ-029 Redirect priority: if_handler > if_eret > if_jump; if_handler and if_eret act in every state regardless of stall.
REQ-030 Redirect in HOLD: pc<=target, state FETCH, instr_valid=0 next cycle.
REQ-031 Redirect in FETCH with mem_ready same cycle: mem_rdata discarded, pc<=target, stay FETCH.
REQ-032 Redirect in FETCH without mem_ready: pc<=target, state FLUSH if request was issued (legal pc), else FETCH.
REQ-033 FLUSH: mem_req=1, mem_addr=req_addr; on mem_ready discard data, state FETCH; instr_valid=0 throughout.
REQ-034 Redirect in FLUSH: pc overwritten by newest target, stay FLUSH.
REQ-035 Illegal redirect target handled by REQ-024 on next FETCH; no memory access to illegal address.

Reset
REQ-036 While Reset=1 at a clk edge: pc=IM_INIT, req_addr=IM_INIT, instr=0, IFU_EXC=NO_EXC, instr_valid=0, state FETCH; mem_req forced 0 during the Reset cycle.
REQ-037 Reset mid-fetch or in FLUSH abandons the outstanding request; any later mem_ready with no request is ignored.

Verification
REQ-038 Reset, mem_ready 2 cycles after each req, stall=0, rdata=addr -> fetches 0x3000, 0x3004, 0x3008; instr_valid pulses with matching PC/instr.
REQ-039 HOLD at 0x3004, stall=1 for 3 cycles, if_jump=1 -> outputs frozen; after stall drops, next mem_addr=next_pc 0x3100.
REQ-040 Fetch to 0x3008 outstanding, if_handler=1 handler_pc=0x4180 -> FLUSH, mem_addr stays 0x3008 until mem_ready, data dropped, next mem_addr=0x4180.
REQ-041 if_eret=1 epc=0x3002 in HOLD -> mem_req stays 0, instr_valid=1, PC=0x3002, instr=0, IFU_EXC=ADEL.
REQ-042 if_handler and if_eret and if_jump same cycle -> handler_pc wins; Reset during FETCH -> next mem_addr=0x3000, no spurious instr_valid.
